// File: rtl/booth_mult_arbiter_if.sv
// Request, response and multiplier-side signals of the shared Booth multiplier arbiter.
// slave is the arbiter view; master is the view of the clients plus the multiplier.
interface booth_mult_arbiter_if #(
   parameter int N       = 18,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*N-1:0] req_mplier;
   logic [NUM_REQ*N-1:0] req_mcand;

   logic                 resp_valid;
   logic                 resp_ready;
   logic [ID_W-1:0]      resp_id;
   logic [2*N-1:0]       resp_product;

   logic                 mult_start;
   logic [N-1:0]         mult_mplier;
   logic [N-1:0]         mult_mcand;
   logic                 mult_done;
   logic [2*N-1:0]       mult_product;

   modport slave (
      input  req_valid, req_mplier, req_mcand, resp_ready, mult_done, mult_product,
      output req_ready, resp_valid, resp_id, resp_product, mult_start, mult_mplier, mult_mcand
   );

   modport master (
      output req_valid, req_mplier, req_mcand, resp_ready, mult_done, mult_product,
      input  req_ready, resp_valid, resp_id, resp_product, mult_start, mult_mplier, mult_mcand
   );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential radix-4 Booth multiplier among NUM_REQ clients.
// Optional BOOTH_ARB_STATS_EN adds saturating stat_ops / stat_busy counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | arbitrating; req_ready one-hot for the round-robin winner
//   S_ISSUE   | operands registered; mult_start pulses for this cycle
//   S_WAIT    | multiplier busy; waiting for mult_done
//   S_CAPTURE | mult_product valid; latched into resp_product
//   S_RESP    | resp_valid high; held until resp_ready
module booth_mult_arbiter #(
   parameter int  N       = 18,
   parameter int  NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                clk,
   input  logic                n_reset,
   booth_mult_arbiter_if.slave bus
`ifdef BOOTH_ARB_STATS_EN
   ,
   output logic [31:0]         stat_ops,
   output logic [31:0]         stat_busy
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [ID_W-1:0]    rr_last;
   logic [ID_W-1:0]    cur_id;
   logic [N-1:0]       mplier_q;
   logic [N-1:0]       mcand_q;
   logic [2*N-1:0]     product_q;

   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    grant_id;
   logic               found;
   logic [NUM_REQ-1:0] grant;
   logic               xfer;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      cand     = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_last) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found    = 1'b1;
            grant_id = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found && (state == S_IDLE) && !n_reset) begin
         grant[grant_id] = 1'b1;
      end
   end

   assign xfer = |(bus.req_valid & grant);

   always_ff @(posedge clk) begin
      if (n_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (xfer) state_nxt = S_ISSUE;
         S_ISSUE:   state_nxt = S_WAIT;
         S_WAIT:    if (bus.mult_done) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_RESP;
         S_RESP:    if (bus.resp_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_reset) begin
         rr_last   <= ID_W'(NUM_REQ - 1);
         cur_id    <= '0;
         mplier_q  <= '0;
         mcand_q   <= '0;
         product_q <= '0;
      end else begin
         if (xfer) begin
            rr_last  <= grant_id;
            cur_id   <= grant_id;
            mplier_q <= bus.req_mplier[int'(grant_id)*N +: N];
            mcand_q  <= bus.req_mcand[int'(grant_id)*N +: N];
         end
         // The multiplier presents its result only in the cycle after mult_done.
         if (state == S_CAPTURE) begin
            product_q <= bus.mult_product;
         end
      end
   end

   assign bus.req_ready    = grant;
   assign bus.mult_start   = (state == S_ISSUE);
   assign bus.mult_mplier  = mplier_q;
   assign bus.mult_mcand   = mcand_q;
   assign bus.resp_valid   = (state == S_RESP);
   assign bus.resp_id      = cur_id;
   assign bus.resp_product = product_q;

`ifdef BOOTH_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (n_reset) begin
         stat_ops  <= '0;
         stat_busy <= '0;
      end else begin
         if ((state == S_RESP) && bus.resp_ready && (stat_ops != '1)) begin
            stat_ops <= stat_ops + 32'd1;
         end
         if ((state != S_IDLE) && (stat_busy != '1)) begin
            stat_busy <= stat_busy + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural N/2-cycle multiplier model.
module tb_booth_mult_arbiter;
   localparam int N       = 18;
   localparam int NUM_REQ = 4;
   localparam int PW      = 2 * N;

   logic clk = 1'b0;
   logic n_reset = 1'b1;
   always #5 clk = ~clk;

   booth_mult_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

`ifdef BOOTH_ARB_STATS_EN
   logic [31:0] stat_ops;
   logic [31:0] stat_busy;
   booth_mult_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .n_reset(n_reset), .bus(bus), .stat_ops(stat_ops), .stat_busy(stat_busy));
`else
   booth_mult_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .n_reset(n_reset), .bus(bus));
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Multiplier model: done N/2+1 negedges after start is seen, junk product on the done cycle.
   int               mcnt = 0;
   logic             model_done = 1'b0;
   logic             stray_done = 1'b0;
   logic [PW-1:0]    mres = '0;
   logic signed [PW-1:0] sa, sb;
   assign bus.mult_done = model_done | stray_done;

   always @(negedge clk) begin
      if (n_reset) begin
         mcnt = 0;
         model_done = 1'b0;
         bus.mult_product = '0;
      end else begin
         if (model_done) bus.mult_product = mres;
         model_done = 1'b0;
         if (mcnt != 0) begin
            mcnt--;
            if (mcnt == 0) begin
               model_done = 1'b1;
               bus.mult_product = 36'hABCDE1234;
            end
         end
         if (bus.mult_start) begin
            mcnt = N/2 + 1;
            sa = $signed(bus.mult_mplier);
            sb = $signed(bus.mult_mcand);
            mres = sa * sb;
         end
      end
   end

   typedef struct {
      int            id;
      logic [N-1:0]  mpl;
      logic [N-1:0]  mcd;
      logic [PW-1:0] prod;
   } vec_t;

   vec_t vecs[7];

   task automatic run_op(input int id, input logic [N-1:0] mpl, input logic [N-1:0] mcd,
                         input logic [PW-1:0] prod);
      int lat;
      bit start_bad;
      logic [NUM_REQ-1:0] one_hot;
      start_bad = 1'b0;
      one_hot = '0;
      one_hot[id] = 1'b1;
      @(negedge clk);
      bus.req_mplier[id*N +: N] = mpl;
      bus.req_mcand[id*N +: N]  = mcd;
      bus.req_valid  = one_hot;
      bus.resp_ready = 1'b1;
      #1 chk("grant", bus.req_ready, one_hot);
      @(negedge clk);
      bus.req_valid = '0;
      chk("mult_start_t1", bus.mult_start, 1);
      chk("mult_mplier", bus.mult_mplier, mpl);
      chk("mult_mcand", bus.mult_mcand, mcd);
      lat = 1;
      while (!bus.resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!bus.resp_valid && bus.mult_start) start_bad = 1'b1;
      end
      chk("resp_latency", lat, 13);
      chk("resp_id", bus.resp_id, id);
      chk("resp_product", bus.resp_product, prod);
      chk("mult_start_single", start_bad, 0);
      @(negedge clk);
      chk("resp_valid_clear", bus.resp_valid, 0);
   endtask

   initial begin
      int n;
      int exp_id;
      int stable;
      bit busy_grant;
      logic [PW-1:0] held_prod;
      logic [NUM_REQ-1:0] one_hot;

      vecs[0] = '{0, 18'd3,     18'd5,     36'd15};
      vecs[1] = '{2, 18'h3FFF9, 18'd6,     36'hFFFFFFFD6};
      vecs[2] = '{1, 18'h20000, 18'h20000, 36'h400000000};
      vecs[3] = '{3, 18'h1FFFF, 18'h1FFFF, 36'h3FFFC0001};
      vecs[4] = '{0, 18'h20000, 18'h1FFFF, 36'hC00020000};
      vecs[5] = '{2, 18'd0,     18'h3FFFF, 36'd0};
      vecs[6] = '{1, 18'h3FFFF, 18'h3FFFF, 36'd1};

      bus.req_valid  = '0;
      bus.req_mplier = '0;
      bus.req_mcand  = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_reset = 1'b0;
      #1;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_id", bus.resp_id, 0);
      chk("rst_resp_product", bus.resp_product, 0);
      chk("rst_mult_start", bus.mult_start, 0);
      chk("rst_mult_mplier", bus.mult_mplier, 0);
      chk("rst_mult_mcand", bus.mult_mcand, 0);

      for (int v = 0; v < 7; v++) run_op(vecs[v].id, vecs[v].mpl, vecs[v].mcd, vecs[v].prod);

      // All requesters held valid from reset: grants rotate 0,1,2,3,0.
      @(negedge clk);
      n_reset = 1'b1;
      bus.req_valid  = 4'hF;
      bus.req_mplier = {18'd4, 18'd3, 18'd2, 18'd1};
      bus.req_mcand  = {18'd10, 18'd10, 18'd10, 18'd10};
      bus.resp_ready = 1'b1;
      #1 chk("req_ready_in_reset", bus.req_ready, 0);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      for (int g = 0; g < 5; g++) begin
         exp_id = g % NUM_REQ;
         one_hot = '0;
         one_hot[exp_id] = 1'b1;
         n = 0;
         while (bus.req_ready == 0 && n < 30) begin
            @(negedge clk);
            n++;
         end
         chk("rr_grant", bus.req_ready, one_hot);
         busy_grant = 1'b0;
         n = 0;
         @(negedge clk);
         while (!bus.resp_valid && n < 40) begin
            if (bus.req_ready != 0) busy_grant = 1'b1;
            @(negedge clk);
            n++;
         end
         chk("rr_no_grant_busy", busy_grant, 0);
         chk("rr_resp_id", bus.resp_id, exp_id);
         chk("rr_resp_product", bus.resp_product, PW'(10 * (exp_id + 1)));
         @(negedge clk);
      end
      bus.req_valid = '0;

      // Backpressure: req3 stalls 20 cycles in RESP while req1 waits; a stray done is ignored.
      @(negedge clk);
      bus.req_mplier[3*N +: N] = 18'h3FFFE;
      bus.req_mcand[3*N +: N]  = 18'd7;
      bus.req_mplier[1*N +: N] = 18'd100;
      bus.req_mcand[1*N +: N]  = 18'h3FFFD;
      bus.req_valid  = 4'b1000;
      bus.resp_ready = 1'b0;
      #1 chk("bp_grant", bus.req_ready, 4'b1000);
      @(negedge clk);
      bus.req_valid = 4'b0010;
      n = 0;
      while (!bus.resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_resp_id", bus.resp_id, 3);
      chk("bp_resp_product", bus.resp_product, 36'hFFFFFFFF2);
      held_prod = bus.resp_product;
      stable = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         stray_done = (i == 5);
         if (bus.resp_valid && bus.resp_id == 3 && bus.resp_product == held_prod &&
             bus.mult_mplier == 18'h3FFFE && bus.mult_mcand == 18'd7 &&
             bus.req_ready == 0 && !bus.mult_start)
            stable++;
      end
      stray_done = 1'b0;
      chk("bp_stable_cycles", stable, 20);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_resp_valid_clear", bus.resp_valid, 0);
      chk("bp_next_grant", bus.req_ready, 4'b0010);
      @(negedge clk);
      bus.req_valid = '0;
      n = 0;
      while (!bus.resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp2_resp_id", bus.resp_id, 1);
      chk("bp2_resp_product", bus.resp_product, 36'hFFFFFFED4);
      @(negedge clk);
      chk("bp2_resp_valid_clear", bus.resp_valid, 0);
`ifdef BOOTH_ARB_STATS_EN
      chk("stat_ops", stat_ops, 7);
      chk("stat_busy", stat_busy, 111);
`endif

      // Reset five cycles into an operation discards it.
      @(negedge clk);
      bus.req_mplier[2*N +: N] = 18'd9;
      bus.req_mcand[2*N +: N]  = 18'd9;
      bus.req_valid = 4'b0100;
      #1 chk("mid_grant", bus.req_ready, 4'b0100);
      @(negedge clk);
      bus.req_valid = '0;
      repeat (4) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_resp_valid", bus.resp_valid, 0);
      chk("mid_rst_resp_id", bus.resp_id, 0);
      chk("mid_rst_resp_product", bus.resp_product, 0);
      chk("mid_rst_mult_start", bus.mult_start, 0);
      chk("mid_rst_mult_mplier", bus.mult_mplier, 0);
      chk("mid_rst_mult_mcand", bus.mult_mcand, 0);
      chk("mid_rst_req_ready", bus.req_ready, 0);
`ifdef BOOTH_ARB_STATS_EN
      chk("mid_rst_stat_ops", stat_ops, 0);
      chk("mid_rst_stat_busy", stat_busy, 0);
`endif
      n_reset = 1'b0;
      busy_grant = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.resp_valid || bus.mult_start) busy_grant = 1'b1;
      end
      chk("mid_rst_no_resp", busy_grant, 0);
      bus.req_valid = 4'hF;
      #1 chk("mid_rst_rr_last", bus.req_ready, 4'b0001);
      bus.req_valid = '0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
